mmio_io_responder: RTL
======================

# mmio_io_responder

Memory-mapped I/O responder on the processor data bus. It decodes one address window and serves word-wide register reads and writes for the board LEDs, seven-segment displays, switches, keys, and a free-running timer with compare. Read timing matches the data RAM: registered read data with a one-cycle `rdata_valid`. The top level ORs this block's read path with the RAM's, and gates RAM writes, on the window-select decode.

## Interface
- `BASE_ADDR`, default 32'h8000_0000: window base. The window is the 4 KiB region where `addr[31:12] == BASE_ADDR[31:12]`.
- `clk` in, 1: system clock (clock_50 at top).
- `reset_n` in, 1: asynchronous, active-low reset.
- `addr` in, 32: processor data address; byte address, word-aligned.
- `we` in, 1: write enable for the current cycle.
- `wdata` in, 32: write data.
- `rdata` out, 32: registered read data.
- `rdata_valid` out, 1: `rdata` holds the response to the previous cycle's read.
- `sel` out, 1: combinational; `addr` is inside the window.
- `sw` in, 10: raw slide switches.
- `key` in, 4: raw push buttons, active-low.
- `ledr` out, 10: LED register.
- `hex0`..`hex5` out, 7 each: segment drive, active-low, decoded from the HEX register nibbles.
- `irq` out, 1: equals the sticky match flag.

## Operation
- Decode uses word offset `addr[11:2]`. Register map (byte offsets):
  - 0x00 LEDR: RW, bits [9:0].
  - 0x04 HEX: RW, bits [23:0]. Nibble k drives `hexk`; values 0–F show hex glyphs.
  - 0x08 SW: RO, bits [9:0], synchronized.
  - 0x0C KEY: RO, bits [3:0], synchronized and inverted (pressed = 1).
  - 0x10 TIMER: RW, 32 bits. Increments every cycle; a write loads `wdata`.
  - 0x14 CMP: RW, 32 bits.
  - 0x18 STATUS: bit0 = MATCH, sticky. Writing 1 to bit0 clears it.
  - Unmapped offsets: read 0, writes ignored.
- Read access: `sel & ~we`. Write access: `sel & we`. Unused high bits of every register read as 0.
- `sw` and `key` pass through 2-flop synchronizers before use.
- TIMER wraps from 0xFFFF_FFFF to 0.
- MATCH sets on any cycle where TIMER == CMP (pre-increment value).
- Simultaneous events:
  - TIMER write and increment in the same cycle: the write wins; the next cycle counts from `wdata`.
  - MATCH set and clear in the same cycle: set wins.
  - CMP write: takes effect for the comparison on the next cycle.
- Reset mid-operation clears all state immediately, including a pending `rdata_valid`.

## Timing
- Reset values:
  - `ledr` = 0, HEX = 0, so every `hexk` = 7'b1000000 (glyph "0").
  - `rdata` = 0, `rdata_valid` = 0.
  - TIMER = 0, CMP = 32'hFFFF_FFFF, MATCH = 0, `irq` = 0.
  - Synchronizer flops = 0 for `sw`; 4'hF (released) for `key`.
- Write: registered at the rising edge of the access cycle. Visible on `ledr`/`hexk` the following cycle.
- Read: access in cycle N. `rdata_valid` = 1 and `rdata` = register value in cycle N+1.
  - Outside a read, `rdata_valid` = 0 and `rdata` = 0, which makes the top-level OR-merge safe.
- Back-to-back reads every cycle are supported at full throughput with no stalls.
- A write followed by a read of the same register in the next cycle returns the new value.
- Input latency: a `sw` change is readable 2 cycles later, i.e. `rdata` reflects it at most 3 cycles after the change.
- `irq` follows MATCH and rises one cycle after the equality cycle.

## Structure
- Package `io_map_pkg`:
  - Offset constants `IO_LEDR`, `IO_HEX`, `IO_SW`, `IO_KEY`, `IO_TIMER`, `IO_CMP`, `IO_STATUS`.
  - `IO_BASE_DEFAULT`.
  - Reset constants for CMP and the HEX glyph.
- Sub-module `hex7seg`: combinational 4-bit to 7-segment active-low decoder, instantiated 6 times.
- Everything else (decode, registers, timer, synchronizers, read mux) lives in one module.

## Test plan
- Reset: assert `reset_n` = 0 mid-count → `ledr` = 0, `hex0`..`hex5` = 7'b1000000, `rdata_valid` = 0, `irq` = 0; after release, reading 0x8000_0014 returns 0xFFFF_FFFF.
- LED/HEX write-read: write 0x3FF to 0x8000_0000 and 0x00A5_0F01 to 0x8000_0004 → `ledr` = 0x3FF, `hex0` = glyph "1", `hex2` = glyph "F", `hex4` = glyph "5"; back-to-back reads return 0x3FF then 0x00A5_0F01, each with `rdata_valid` one cycle later.
- Inputs: `sw` = 0x155, `key` = 4'b1110 → reading 0x08 gives 0x155 and reading 0x0C gives 0x1; a read issued 1 cycle after the change still returns the old value.
- Timer/compare: write TIMER = 0xFFFF_FFFE, CMP = 0x0000_0001 → wraps through 0; MATCH and `irq` rise one cycle after TIMER == 1; write 1 to STATUS clears it. A clear in the same cycle as a match leaves `irq` = 1.
- Decode: read 0x8000_0100 → `rdata` = 0 with `rdata_valid` = 1; read 0x0000_0010 → `sel` = 0 and `rdata_valid` = 0; a write to 0x7FFF_F000 leaves all registers unchanged.

Source files
------------

// File: rtl/io_map_pkg.sv
// io_map_pkg: shared constants for the memory-mapped I/O responder.
//   - window base default
//   - register byte offsets inside the 4 KiB window
//   - reset values for CMP and the HEX "0" glyph
package io_map_pkg;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h8000_0000;

  // Byte offsets; decode compares against addr[11:2] with the low bits zeroed.
  localparam logic [11:0] IO_LEDR   = 12'h000;
  localparam logic [11:0] IO_HEX    = 12'h004;
  localparam logic [11:0] IO_SW     = 12'h008;
  localparam logic [11:0] IO_KEY    = 12'h00C;
  localparam logic [11:0] IO_TIMER  = 12'h010;
  localparam logic [11:0] IO_CMP    = 12'h014;
  localparam logic [11:0] IO_STATUS = 12'h018;

  localparam logic [31:0] CMP_RESET      = 32'hFFFF_FFFF;
  localparam logic [6:0]  HEX_GLYPH_ZERO = 7'b1000000;

endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational 4-bit to seven-segment decoder, active-low.
//   nibble_i [3:0] : value to display (0-F)
//   seg_o    [6:0] : segments {g,f,e,d,c,b,a}, 0 = lit
module hex7seg
  import io_map_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = HEX_GLYPH_ZERO;
    unique case (nibble_i)
      4'h0: seg_o = HEX_GLYPH_ZERO;
      4'h1: seg_o = 7'b1111001;
      4'h2: seg_o = 7'b0100100;
      4'h3: seg_o = 7'b0110000;
      4'h4: seg_o = 7'b0011001;
      4'h5: seg_o = 7'b0010010;
      4'h6: seg_o = 7'b0000010;
      4'h7: seg_o = 7'b1111000;
      4'h8: seg_o = 7'b0000000;
      4'h9: seg_o = 7'b0010000;
      4'hA: seg_o = 7'b0001000;
      4'hB: seg_o = 7'b0000011;
      4'hC: seg_o = 7'b1000110;
      4'hD: seg_o = 7'b0100001;
      4'hE: seg_o = 7'b0000110;
      4'hF: seg_o = 7'b0001110;
      default: seg_o = HEX_GLYPH_ZERO;
    endcase
  end

endmodule

// File: rtl/mmio_io_responder.sv
// mmio_io_responder: decodes one 4 KiB window on the data bus and serves
// word-wide access to LEDs, seven-segment HEX, switches, keys and a
// free-running timer with compare/match interrupt.
//   clk_i, reset_n_i       : system clock, async active-low reset
//   addr_i, we_i, wdata_i  : processor data bus request
//   rdata_o, rdata_valid_o : registered read response (0 when not reading)
//   sel_o                  : combinational window hit
//   sw_i, key_i            : raw board inputs (key active-low)
//   ledr_o, hex0_o..hex5_o : board outputs
//   irq_o                  : sticky MATCH flag
module mmio_io_responder
  import io_map_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = IO_BASE_DEFAULT
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        rdata_valid_o,
  output logic        sel_o,
  input  logic [9:0]  sw_i,
  input  logic [3:0]  key_i,
  output logic [9:0]  ledr_o,
  output logic [6:0]  hex0_o,
  output logic [6:0]  hex1_o,
  output logic [6:0]  hex2_o,
  output logic [6:0]  hex3_o,
  output logic [6:0]  hex4_o,
  output logic [6:0]  hex5_o,
  output logic        irq_o
);

  logic [9:0]  ledr_q,  ledr_d;
  logic [23:0] hex_q,   hex_d;
  logic [31:0] timer_q, timer_d;
  logic [31:0] cmp_q,   cmp_d;
  logic        match_q, match_d;
  logic [9:0]  sw_meta_q,  sw_sync_q;
  logic [3:0]  key_meta_q, key_sync_q;
  logic [31:0] rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;

  logic [11:0] off_w;
  logic        rd_acc;
  logic        wr_acc;
  logic [31:0] rd_mux;
  logic        unused_addr;

  // Byte lanes are not decoded; accesses are always full words.
  assign unused_addr = ^addr_i[1:0];

  always_comb begin
    off_w  = {addr_i[11:2], 2'b00};
    sel_o  = (addr_i[31:12] == BASE_ADDR[31:12]);
    rd_acc = sel_o & ~we_i;
    wr_acc = sel_o & we_i;
  end

  always_comb begin
    rd_mux = '0;
    case (off_w)
      IO_LEDR:   rd_mux = {22'd0, ledr_q};
      IO_HEX:    rd_mux = {8'd0, hex_q};
      IO_SW:     rd_mux = {22'd0, sw_sync_q};
      IO_KEY:    rd_mux = {28'd0, ~key_sync_q};
      IO_TIMER:  rd_mux = timer_q;
      IO_CMP:    rd_mux = cmp_q;
      IO_STATUS: rd_mux = {31'd0, match_q};
      default:   rd_mux = '0;
    endcase
  end

  always_comb begin
    ledr_d  = ledr_q;
    hex_d   = hex_q;
    cmp_d   = cmp_q;
    timer_d = timer_q + 32'd1;
    if (wr_acc) begin
      case (off_w)
        IO_LEDR:  ledr_d  = wdata_i[9:0];
        IO_HEX:   hex_d   = wdata_i[23:0];
        IO_TIMER: timer_d = wdata_i;
        IO_CMP:   cmp_d   = wdata_i;
        default:  ;
      endcase
    end
    // Equality uses the current (pre-increment) timer and current CMP, and a
    // set in the same cycle as a software clear must win.
    match_d = (timer_q == cmp_q) |
              (match_q & ~(wr_acc && (off_w == IO_STATUS) && wdata_i[0]));
    // Read data is forced to zero outside a read so the top level can OR it
    // with the RAM read path.
    rdata_d  = rd_acc ? rd_mux : '0;
    rvalid_d = rd_acc;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ledr_q     <= '0;
      hex_q      <= '0;
      timer_q    <= '0;
      cmp_q      <= CMP_RESET;
      match_q    <= 1'b0;
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      key_meta_q <= 4'hF;
      key_sync_q <= 4'hF;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
    end else begin
      ledr_q     <= ledr_d;
      hex_q      <= hex_d;
      timer_q    <= timer_d;
      cmp_q      <= cmp_d;
      match_q    <= match_d;
      sw_meta_q  <= sw_i;
      sw_sync_q  <= sw_meta_q;
      key_meta_q <= key_i;
      key_sync_q <= key_meta_q;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  logic [6:0] seg_w [6];

  for (genvar k = 0; k < 6; k++) begin : g_hex
    hex7seg u_hex7seg (
      .nibble_i(hex_q[4*k +: 4]),
      .seg_o   (seg_w[k])
    );
  end

  assign hex0_o        = seg_w[0];
  assign hex1_o        = seg_w[1];
  assign hex2_o        = seg_w[2];
  assign hex3_o        = seg_w[3];
  assign hex4_o        = seg_w[4];
  assign hex5_o        = seg_w[5];
  assign ledr_o        = ledr_q;
  assign irq_o         = match_q;
  assign rdata_o       = rdata_q;
  assign rdata_valid_o = rvalid_q;

endmodule
